// File: rtl/fib_alu_sequencer_if.sv
// Bus between the Fibonacci sequencer, its run controller and ALU_REG.
// The master side is the sequencer; the slave side is the controller plus ALU_REG.
interface fib_alu_sequencer_if;
    logic        start;
    logic [15:0] n_terms;
    logic        step;
    logic [4:0]  Flags;
    logic [7:0]  opcode;
    logic [3:0]  s_reg1;
    logic [3:0]  s_reg2;
    logic        Imm_ctrl;
    logic [15:0] Imm;
    logic [15:0] Reg_Enable;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] term_count;
    logic [1:0]  last_reg;

    modport master (
        input  start, n_terms, step, Flags,
        output opcode, s_reg1, s_reg2, Imm_ctrl, Imm, Reg_Enable,
               busy, done, overflow, term_count, last_reg
    );

    modport slave (
        output start, n_terms, step, Flags,
        input  opcode, s_reg1, s_reg2, Imm_ctrl, Imm, Reg_Enable,
               busy, done, overflow, term_count, last_reg
    );
endinterface

// File: rtl/fib_alu_sequencer.sv
// Sequences ALU_REG so a Fibonacci series builds up in a rotating r0/r1/r2 window,
// with start/done handshake, term limit, single-step gating and carry abort.
module fib_alu_sequencer #(
    parameter logic [7:0] OP_ADD    = 8'b00000101,
    parameter logic [7:0] OP_MOV    = 8'b00000101,
    parameter int         CARRY_IDX = 0,
    parameter int         NUM_REGS  = 3
) (
    input  logic                       clk,
    input  logic                       Reset,
    fib_alu_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_ADD,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] n_terms_reg, n_terms_next;
    logic [15:0] term_count_reg, term_count_next;
    logic [1:0]  last_idx_reg, last_idx_next;
    logic [1:0]  dst_reg, dst_next;
    logic        overflow_reg, overflow_next;

    logic        carry;
    logic        flags_unused;
    logic [1:0]  src1_idx, src2_idx;
    logic [1:0]  wr_idx;
    logic        wr_active;
    logic [15:0] wr_onehot;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        next_idx = (idx == 2'(NUM_REGS - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign carry        = bus.Flags[CARRY_IDX];
    assign flags_unused = ^bus.Flags;
    assign src1_idx     = next_idx(dst_reg);
    assign src2_idx     = next_idx(src1_idx);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_wr_decode
            if (gi < NUM_REGS) begin : g_win
                assign wr_onehot[gi] = (wr_idx == 2'(gi));
            end else begin : g_none
                assign wr_onehot[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            n_terms_reg    <= 16'd0;
            term_count_reg <= 16'd0;
            last_idx_reg   <= 2'd0;
            dst_reg        <= 2'd0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            n_terms_reg    <= n_terms_next;
            term_count_reg <= term_count_next;
            last_idx_reg   <= last_idx_next;
            dst_reg        <= dst_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        n_terms_next    = n_terms_reg;
        term_count_next = term_count_reg;
        last_idx_next   = last_idx_reg;
        dst_next        = dst_reg;
        overflow_next   = overflow_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    n_terms_next    = bus.n_terms;
                    overflow_next   = 1'b0;
                    term_count_next = 16'd0;
                    state_next      = (bus.n_terms == 16'd0) ? S_DONE : S_INIT0;
                end
            end
            S_INIT0: begin
                if (bus.step) begin
                    term_count_next = 16'd1;
                    last_idx_next   = 2'd0;
                    state_next      = (n_terms_reg == 16'd1) ? S_DONE : S_INIT1;
                end
            end
            S_INIT1: begin
                if (bus.step) begin
                    term_count_next = 16'd2;
                    last_idx_next   = 2'd1;
                    dst_next        = 2'd2;
                    state_next      = (n_terms_reg == 16'd2) ? S_DONE : S_ADD;
                end
            end
            S_ADD: begin
                if (bus.step) begin
                    // On carry the wrapped sum is already in dst; keep the last valid term.
                    if (carry) begin
                        overflow_next = 1'b1;
                        state_next    = S_DONE;
                    end else begin
                        term_count_next = term_count_reg + 16'd1;
                        last_idx_next   = dst_reg;
                        dst_next        = next_idx(dst_reg);
                        if (term_count_reg + 16'd1 == n_terms_reg) begin
                            state_next = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.opcode   = OP_ADD;
        bus.s_reg1   = 4'd0;
        bus.s_reg2   = 4'd0;
        bus.Imm_ctrl = 1'b0;
        bus.Imm      = 16'd0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        wr_active    = 1'b0;
        wr_idx       = 2'd0;
        case (state_reg)
            S_INIT0: begin
                bus.opcode   = OP_MOV;
                bus.Imm_ctrl = 1'b1;
                bus.Imm      = 16'd0;
                bus.busy     = 1'b1;
                wr_active    = 1'b1;
                wr_idx       = 2'd0;
            end
            S_INIT1: begin
                bus.opcode   = OP_MOV;
                bus.Imm_ctrl = 1'b1;
                bus.Imm      = 16'd1;
                bus.busy     = 1'b1;
                wr_active    = 1'b1;
                wr_idx       = 2'd1;
            end
            S_ADD: begin
                bus.s_reg1 = {2'b00, src1_idx};
                bus.s_reg2 = {2'b00, src2_idx};
                bus.busy   = 1'b1;
                wr_active  = 1'b1;
                wr_idx     = dst_reg;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The write strobe alone is gated by step and Reset so a stalled or reset cycle never writes.
    assign bus.Reg_Enable = (wr_active && bus.step && !Reset) ? wr_onehot : 16'd0;
    assign bus.overflow   = overflow_reg;
    assign bus.term_count = term_count_reg;
    assign bus.last_reg   = last_idx_reg;

endmodule

// File: tb/tb_fib_alu_sequencer.sv
// Randomized self-checking bench: an ALU_REG model plus a queue of expected
// Fibonacci writes derived directly from the series definition.
module tb_fib_alu_sequencer;

    typedef struct {
        int idx;
        int val;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fib_alu_sequencer_if bus();

    fib_alu_sequencer dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [15:0] alu_r [0:15] = '{default: 16'h0};
    logic [16:0] alu_sum;

    always_comb begin
        if (bus.Imm_ctrl)
            alu_sum = {1'b0, bus.Imm};
        else
            alu_sum = {1'b0, alu_r[bus.s_reg1]} + {1'b0, alu_r[bus.s_reg2]};
        bus.Flags = {4'b0000, alu_sum[16]};
    end

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (bus.Reg_Enable[i] === 1'b1) alu_r[i] <= alu_sum[15:0];
    end

    int  total = 0;
    int  bad = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    int  last_wr_cyc = -10;
    int  fib [0:25];
    int  exp_n = 0;
    int  exp_tc = 0;
    int  exp_last = 0;
    int  exp_ovf = 0;
    int  model_last = 0;
    wr_t exp_q [$];

    function automatic void push_expect(input int n);
        int  tc;
        wr_t w;
        tc = (n > 25) ? 25 : n;
        for (int k = 0; k < tc; k++) begin
            w.idx = k % 3;
            w.val = fib[k] & 32'hFFFF;
            exp_q.push_back(w);
        end
        if (n > 25) begin
            w.idx = 25 % 3;
            w.val = fib[25] & 32'hFFFF;
            exp_q.push_back(w);
        end
        exp_n   = n;
        exp_tc  = tc;
        exp_ovf = (n > 25) ? 1 : 0;
        if (tc > 0) model_last = (tc - 1) % 3;
        exp_last = model_last;
    endfunction

    // Compare process: every write and every done pulse is checked against the model.
    always @(negedge clk) begin
        wr_t         e;
        logic [15:0] exp_en;
        cyc = cyc + 1;
        if (bus.Reg_Enable != 16'h0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write en=%h val=%0d expected no write", bus.Reg_Enable, alu_sum[15:0]);
            end else begin
                e = exp_q.pop_front();
                exp_en = 16'd1 << e.idx;
                if (bus.Reg_Enable !== exp_en || alu_sum[15:0] !== 16'(e.val) || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL write en=%h val=%0d busy=%b required en=%h val=%0d busy=1",
                             bus.Reg_Enable, alu_sum[15:0], bus.busy, exp_en, e.val);
                end
            end
            total++;
            if (bus.step !== 1'b1) begin
                bad++;
                $display("FAIL step_gate write with step=%b required step=1", bus.step);
            end
            last_wr_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            total++;
            if (bus.term_count !== 16'(exp_tc) || bus.last_reg !== 2'(exp_last) ||
                bus.overflow !== 1'(exp_ovf) || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL done_state tc=%0d last=%0d ovf=%b busy=%b required tc=%0d last=%0d ovf=%0d busy=0",
                         bus.term_count, bus.last_reg, bus.overflow, bus.busy, exp_tc, exp_last, exp_ovf);
            end
            if (exp_n > 0) begin
                total++;
                if (cyc != last_wr_cyc + 1) begin
                    bad++;
                    $display("FAIL done_timing done at cycle %0d required %0d", cyc, last_wr_cyc + 1);
                end
            end
        end
    end

    task automatic check_reset(input string name);
        logic [69:0] got;
        logic [69:0] want;
        got  = {bus.opcode, bus.s_reg1, bus.s_reg2, bus.Imm_ctrl, bus.Imm, bus.Reg_Enable,
                bus.busy, bus.done, bus.overflow, bus.term_count, bus.last_reg};
        want = {8'b00000101, 62'd0};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s outputs=%h required %h", name, got, want);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // mode 0: step tied high, 1: step pattern 1,0,0, 2: random step.
    task automatic run(input int n, input int mode, input bit hold);
        int target;
        bit released;
        push_expect(n);
        if (hold) push_expect(n);
        target = done_cnt + (hold ? 2 : 1);
        released = 1'b0;
        bus.n_terms = 16'(n);
        bus.start = 1'b1;
        for (int c = 0; c < 400 && done_cnt < target; c++) begin
            case (mode)
                0:       bus.step = 1'b1;
                1:       bus.step = (c % 3 == 0);
                default: bus.step = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            #1;
            if (!hold) begin
                bus.start = 1'b0;
            end else if (done_cnt >= target - 1) begin
                if (released) bus.start = 1'b0;
                else released = 1'b1;
            end
        end
        bus.start = 1'b0;
        check_val("done_seen", done_cnt, target);
        check_val("leftover_writes", exp_q.size(), 0);
        exp_q.delete();
        $display("run n=%0d mode=%0d hold=%0d tc=%0d last=%0d ovf=%0d",
                 n, mode, hold, bus.term_count, bus.last_reg, bus.overflow);
    endtask

    initial begin
        int saved;
        fib[0] = 0;
        fib[1] = 1;
        for (int k = 2; k <= 25; k++) fib[k] = fib[k-1] + fib[k-2];
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n_terms = 16'd0;
        bus.step = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("model_f9", fib[9], 34);
        check_val("model_f24", fib[24], 46368);
        check_val("model_f25_wrapped", fib[25] & 32'hFFFF, 9489);

        run(10, 0, 1'b0);
        check_val("f9_in_r0", int'(alu_r[0]), 34);
        run(0, 0, 1'b0);
        run(1, 0, 1'b0);
        run(2, 0, 1'b0);
        run(40, 0, 1'b0);
        check_val("last_term_46368", int'(alu_r[bus.last_reg]), 46368);
        check_val("wrapped_f25_r1", int'(alu_r[1]), 9489);
        run(12, 1, 1'b0);
        run(5, 0, 1'b1);
        repeat (8) run(int'($urandom_range(0, 30)), 2, 1'b0);

        // Abandon a run in ADD with five terms written.
        push_expect(20);
        bus.n_terms = 16'd20;
        bus.start = 1'b1;
        bus.step = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.term_count == 16'd5) break;
        end
        check_val("reach_tc5", int'(bus.term_count), 5);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_no_write", int'(bus.Reg_Enable), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_midrun");
        exp_q.delete();
        model_last = 0;
        saved = done_cnt;
        repeat (5) @(posedge clk);
        check_val("no_done_after_rst", done_cnt, saved);
        check_val("r2_kept_f2", int'(alu_r[2]), 1);
        $display("run midrun_reset tc=%0d busy=%b", bus.term_count, bus.busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
